// File: rtl/debounce_sched.sv
// debounce_sched: N active-low push-buttons debounced through one
// shared stability counter that is handed to channels round-robin.
module debounce_sched #(
  parameter  int N     = 4,
  parameter  int CNT_W = 16,
  localparam int IW    = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  pb,
  output logic [N-1:0]  pb_state,
  output logic [N-1:0]  pb_down,
  output logic [N-1:0]  pb_up,
  output logic          busy,
  output logic [IW-1:0] owner
);

  typedef enum logic {
    IDLE,
    COUNT
  } st_e;

  st_e              st_q;
  logic [N-1:0]     s0_q;
  logic [N-1:0]     s1_q;
  logic [N-1:0]     lvl_q;
  logic [N-1:0]     down_q;
  logic [N-1:0]     up_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [IW-1:0]    ptr_q;
  logic [IW-1:0]    owner_q;
  logic             busy_q;

  logic [N-1:0]     pend;
  logic             gnt_vld;
  logic [IW-1:0]    gnt_idx;
  int               j_c;
  logic [IW-1:0]    jx_c;

  // Two-flop synchroniser; the inversion makes s1 active high.
  always_ff @(posedge clk) begin
    if (rst) begin
      s0_q <= '0;
      s1_q <= '0;
    end else begin
      s0_q <= ~pb;
      s1_q <= s0_q;
    end
  end

  assign pend  = s1_q ^ lvl_q;
  assign cnt_d = cnt_q + CNT_W'(1);

  // Round-robin pick: walk from ptr+N down to ptr+1 so the
  // nearest pending channel after ptr is the last one written.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    j_c     = 0;
    jx_c    = '0;
    for (int k = N; k >= 1; k--) begin
      j_c  = (int'(ptr_q) + k) % N;
      jx_c = IW'(j_c);
      if (pend[jx_c]) begin
        gnt_vld = 1'b1;
        gnt_idx = jx_c;
      end
    end
  end

  // Scheduler: grant the counter, time the window, commit the toggle.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q    <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= IW'(N - 1);
      owner_q <= '0;
      busy_q  <= 1'b0;
      lvl_q   <= '0;
      down_q  <= '0;
      up_q    <= '0;
    end else begin
      down_q <= '0;
      up_q   <= '0;
      unique case (st_q)
        IDLE: begin
          if (gnt_vld) begin
            owner_q <= gnt_idx;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            st_q    <= COUNT;
          end
        end
        COUNT: begin
          if (!pend[owner_q]) begin
            cnt_q  <= '0;
            ptr_q  <= owner_q;
            busy_q <= 1'b0;
            st_q   <= IDLE;
          end else if (&cnt_q) begin
            lvl_q[owner_q]  <= ~lvl_q[owner_q];
            down_q[owner_q] <= ~lvl_q[owner_q];
            up_q[owner_q]   <= lvl_q[owner_q];
            cnt_q  <= '0;
            ptr_q  <= owner_q;
            busy_q <= 1'b0;
            st_q   <= IDLE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: begin
          st_q   <= IDLE;
          busy_q <= 1'b0;
          cnt_q  <= '0;
        end
      endcase
    end
  end

  assign pb_state = lvl_q;
  assign pb_down  = down_q;
  assign pb_up    = up_q;
  assign busy     = busy_q;
  assign owner    = owner_q;

endmodule

// File: tb/tb_debounce_sched.sv
// tb_debounce_sched: vector table, directed corner sequences and
// randomized stimulus against a timestamp-based reference model.
module tb_debounce_sched;

  localparam int N   = 4;
  localparam int CW  = 4;
  localparam int WIN = 1 << CW;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] pb;
  logic [N-1:0] pb_state;
  logic [N-1:0] pb_down;
  logic [N-1:0] pb_up;
  logic         busy;
  logic [1:0]   owner;

  debounce_sched #(.N(N), .CNT_W(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .pb       (pb),
    .pb_state (pb_state),
    .pb_down  (pb_down),
    .pb_up    (pb_up),
    .busy     (busy),
    .owner    (owner)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int ecount = 0;

  // reference model: levels, a two-deep input history and the
  // edge number at which the current window was granted
  logic [N-1:0] m_h0, m_h1, m_lvl, m_dn, m_up;
  bit           m_busy;
  int           m_own, m_last, m_t0;

  typedef struct {
    logic [N-1:0] pb;
    int           cyc;
    logic [N-1:0] st;
    logic [N-1:0] dn;
    logic [N-1:0] up;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (edge %0d)",
               nm, act, exp, ecount);
    end
  endtask

  task automatic model_reset();
    m_h0 = '0; m_h1 = '0; m_lvl = '0;
    m_dn = '0; m_up = '0;
    m_busy = 0; m_own = 0; m_last = N - 1; m_t0 = 0;
  endtask

  task automatic model_edge(input logic [N-1:0] p,
                            input logic r);
    logic [N-1:0] want;
    int g;
    if (r) begin
      model_reset();
      return;
    end
    want = m_h1 ^ m_lvl;
    m_dn = '0;
    m_up = '0;
    if (!m_busy) begin
      g = -1;
      for (int k = 1; k <= N; k++)
        if (g < 0 && want[(m_last + k) % N])
          g = (m_last + k) % N;
      if (g >= 0) begin
        m_busy = 1; m_own = g; m_t0 = ecount;
      end
    end else if (!want[m_own]) begin
      m_busy = 0; m_last = m_own;
    end else if (ecount - m_t0 == WIN) begin
      if (m_lvl[m_own]) m_up[m_own] = 1'b1;
      else m_dn[m_own] = 1'b1;
      m_lvl[m_own] = ~m_lvl[m_own];
      m_busy = 0; m_last = m_own;
    end
    m_h1 = m_h0;
    m_h0 = ~p;
  endtask

  task automatic tick();
    ecount++;
    model_edge(pb, rst);
    @(posedge clk);
    #1;
    chk("m_state", pb_state, m_lvl);
    chk("m_down", pb_down, m_dn);
    chk("m_up", pb_up, m_up);
    chk("m_busy", busy, m_busy);
    if (m_busy) chk("m_owner", owner, m_own);
    chk("excl", pb_down & pb_up, 0);
    chk("one_ch", $countones(pb_down | pb_up) <= 1, 1);
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    tbl[0]  = '{4'b1110, 18, 4'b0000, 4'b0000, 4'b0000};
    tbl[1]  = '{4'b1110,  1, 4'b0001, 4'b0001, 4'b0000};
    tbl[2]  = '{4'b1110,  1, 4'b0001, 4'b0000, 4'b0000};
    tbl[3]  = '{4'b1111, 18, 4'b0001, 4'b0000, 4'b0000};
    tbl[4]  = '{4'b1111,  1, 4'b0000, 4'b0000, 4'b0001};
    tbl[5]  = '{4'b0011, 18, 4'b0000, 4'b0000, 4'b0000};
    tbl[6]  = '{4'b0011,  1, 4'b0100, 4'b0100, 4'b0000};
    tbl[7]  = '{4'b0011, 16, 4'b0100, 4'b0000, 4'b0000};
    tbl[8]  = '{4'b0011,  1, 4'b1100, 4'b1000, 4'b0000};
    tbl[9]  = '{4'b1111, 18, 4'b1100, 4'b0000, 4'b0000};
    tbl[10] = '{4'b1111,  1, 4'b1000, 4'b0000, 4'b0100};
    tbl[11] = '{4'b1111, 16, 4'b1000, 4'b0000, 4'b0000};
    tbl[12] = '{4'b1111,  1, 4'b0000, 4'b0000, 4'b1000};

    model_reset();
    rst = 1'b1;
    pb  = '1;
    tick();
    chk("rst_state", pb_state, 0);
    chk("rst_down", pb_down, 0);
    chk("rst_up", pb_up, 0);
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 0);
    rst = 1'b0;

    // single press/release, then a simultaneous pair
    for (int i = 0; i < 13; i++) begin
      pb = tbl[i].pb;
      idle_n(tbl[i].cyc);
      chk($sformatf("tbl%0d_st", i), pb_state, tbl[i].st);
      chk($sformatf("tbl%0d_dn", i), pb_down, tbl[i].dn);
      chk($sformatf("tbl%0d_up", i), pb_up, tbl[i].up);
    end

    // all four pressed then released: rotation 0,1,2,3
    pb = 4'b0000;
    for (int t = 1; t <= 72; t++) begin
      logic [N-1:0] e;
      tick();
      e = '0;
      for (int k = 0; k < N; k++)
        if (t == 19 + 17 * k) e[k] = 1'b1;
      chk("rot_dn", pb_down, e);
    end
    chk("rot_st", pb_state, 4'b1111);
    pb = 4'b1111;
    for (int t = 1; t <= 72; t++) begin
      logic [N-1:0] e;
      tick();
      e = '0;
      for (int k = 0; k < N; k++)
        if (t == 19 + 17 * k) e[k] = 1'b1;
      chk("rot_up", pb_up, e);
    end
    chk("rot_st0", pb_state, 0);

    // short glitch on ch3 while ch0 owns the counter
    for (int t = 1; t <= 25; t++) begin
      pb = (t == 5 || t == 6) ? 4'b0110 : 4'b1110;
      tick();
      chk("gl_dn", pb_down, (t == 19) ? 4'b0001 : 4'b0000);
      chk("gl_own3", busy && owner == 2'd3, 0);
    end
    chk("gl_st", pb_state, 4'b0001);
    pb = 4'b1111;
    idle_n(22);
    chk("gl_rel", pb_state, 0);

    // bouncing ch1, then a stable hold
    for (int b = 0; b < 4; b++) begin
      pb = 4'b1101;
      for (int i = 0; i < 5; i++) begin
        tick();
        chk("bn_quiet", pb_down | pb_up, 0);
      end
      pb = 4'b1111;
      for (int i = 0; i < 3; i++) begin
        tick();
        chk("bn_quiet", pb_down | pb_up, 0);
      end
    end
    pb = 4'b1101;
    for (int t = 1; t <= 19; t++) begin
      tick();
      chk("bn_dn", pb_down, (t == 19) ? 4'b0010 : 4'b0000);
    end
    chk("bn_st", pb_state, 4'b0010);
    pb = 4'b1111;
    idle_n(22);
    chk("bn_rel", pb_state, 0);

    // reset in the middle of ch1's window
    pb = 4'b1101;
    idle_n(13);
    chk("mr_busy", busy, 1);
    chk("mr_owner", owner, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_st", pb_state, 0);
    chk("mr_dn", pb_down, 0);
    chk("mr_busy0", busy, 0);
    for (int t = 1; t <= 19; t++) begin
      tick();
      chk("mr_redo", pb_down, (t == 19) ? 4'b0010 : 4'b0000);
    end
    chk("mr_st1", pb_state, 4'b0010);
    pb = 4'b1111;
    idle_n(22);

    // random buttons, occasional reset
    for (int s = 0; s < 250; s++) begin
      int hold;
      hold = $urandom_range(1, 24);
      pb   = pb ^ 4'($urandom_range(0, 15));
      rst  = ($urandom_range(0, 39) == 0);
      tick();
      rst  = 1'b0;
      idle_n(hold - 1);
    end
    pb = 4'b1111;
    idle_n(4 * (WIN + 3));
    chk("end_busy", busy, 0);
    chk("end_st", pb_state, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
